// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the mincore instruction fetch stage.
package instruction_fetch_pkg;

  localparam int MEMORY_ADDR_W = 32;
  localparam int INST_W        = 32;

  typedef enum logic [2:0] {
    FETCH_REQ   = 3'd0,
    FETCH_WAIT  = 3'd1,
    FETCH_HOLD  = 3'd2,
    FETCH_EXEC  = 3'd3,
    FETCH_FAULT = 3'd4
  } fetch_state_e;

  // Instructions are word aligned; only the two low PC bits decide alignment.
  function automatic logic is_aligned(input logic [1:0] lowBits);
    return lowBits == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch stage, instruction memory, decode and control.
interface instruction_fetch_if import instruction_fetch_pkg::*; ();

  logic [MEMORY_ADDR_W-1:0] next_pc;
  logic                     pc_update;
  logic [MEMORY_ADDR_W-1:0] pc;

  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [MEMORY_ADDR_W-1:0] imem_addr;
  logic                     imem_rsp_valid;
  logic [INST_W-1:0]        imem_rsp_data;

  logic                     inst_valid;
  logic                     inst_ready;
  logic [INST_W-1:0]        inst;
  logic [MEMORY_ADDR_W-1:0] inst_pc;
  logic                     fetch_fault;

  // The fetch stage itself.
  modport master (
    input  next_pc, pc_update, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output pc, imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_fault
  );

  // Everything around the fetch stage: memory, decode, control and the PC mux.
  modport slave (
    output next_pc, pc_update, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  pc, imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_fault
  );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the architectural PC, issues one memory read per
// instruction, holds the fetched word for decode and waits for control to commit
// the next PC.
module instruction_fetch import instruction_fetch_pkg::*; #(
  parameter logic [MEMORY_ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_fetch_if.master  bus
);

  fetch_state_e             state_q, state_d;
  logic [MEMORY_ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0]        inst_q, inst_d;
  logic [MEMORY_ADDR_W-1:0] instPc_q, instPc_d;

  // All outputs are decoded from registered state only, so the request valid never
  // depends on ready and the address cannot move while a request is pending.
  assign bus.pc             = pc_q;
  assign bus.imem_addr      = pc_q;
  assign bus.imem_req_valid = (state_q == FETCH_REQ) && is_aligned(pc_q[1:0]);
  assign bus.inst_valid     = (state_q == FETCH_HOLD);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = instPc_q;
  assign bus.fetch_fault    = (state_q == FETCH_FAULT);

  // State, PC and instruction holding registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH_REQ;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      instPc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      instPc_q <= instPc_d;
    end
  end

  // Walk one instruction through request, response, decode hand-off and commit.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    instPc_d = instPc_q;
    unique case (state_q)
      FETCH_REQ: begin
        if (!is_aligned(pc_q[1:0])) begin
          state_d = FETCH_FAULT;
        end else if (bus.imem_req_ready) begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (bus.imem_rsp_valid) begin
          inst_d   = bus.imem_rsp_data;
          instPc_d = pc_q;
          state_d  = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (bus.inst_ready) begin
          state_d = FETCH_EXEC;
        end
      end
      FETCH_EXEC, FETCH_FAULT: begin
        if (bus.pc_update) begin
          pc_d    = bus.next_pc;
          state_d = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  // A commit is only meaningful once the current instruction has been handed off.
  ignoredCommit: assert property (@(posedge clk) disable iff (!rst_n)
      bus.pc_update |-> (state_q == FETCH_EXEC || state_q == FETCH_FAULT))
    else $warning("instruction_fetch: pc_update ignored in state %s", state_q.name());

  // A response with no read outstanding is dropped.
  strayResponse: assert property (@(posedge clk) disable iff (!rst_n)
      bus.imem_rsp_valid |-> (state_q == FETCH_WAIT))
    else $warning("instruction_fetch: imem_rsp_valid ignored in state %s", state_q.name());

endmodule
